mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port inst_req  input  1  fetch request, held until acked.
REQ-005 SHALL have port inst_addr  input  32  fetch byte address.
REQ-006 SHALL have port inst_ack  output  1  fetch request granted this cycle.
REQ-007 SHALL have port inst_rvalid  output  1  fetch data valid pulse.
REQ-008 SHALL have port inst_rdata  output  32  fetch word.
REQ-009 SHALL have port data_req  input  1  load/store request, held until acked.
REQ-010 SHALL have port data_we  input  1  1=store, 0=load.
REQ-011 SHALL have port data_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL have port data_addr  input  32  data byte address.
REQ-013 SHALL have port data_wdata  input  32  store data, right-justified.
REQ-014 SHALL have port data_ack  output  1  data request accepted this cycle.
REQ-015 SHALL have port data_err  output  1  misaligned/illegal request, pulses with data_ack.
REQ-016 SHALL have port data_rvalid  output  1  load data valid pulse.
REQ-017 SHALL have port data_rdata  output  32  raw aligned load word (sub-word extraction done downstream).
REQ-018 SHALL have ports sram_en/sram_wen/sram_addr/sram_wdata  output  1/4/32/32  registered single SRAM port.
REQ-019 SHALL have port sram_rdata  input  32  SRAM read data, valid one cycle after sram_en.
REQ-020 SHALL have port stallreq  output  1  pipeline stall request.

Function
REQ-021 SHALL arbitrate combinationally each cycle; at most one of inst_ack/data_ack high per cycle.
REQ-022 SHALL grant data over inst, except when starve counter == STARVE_MAX and inst_req high, then grant inst.
REQ-023 Starve counter SHALL increment (saturating at STARVE_MAX) when data granted while inst_req high; clear on inst grant or when inst_req low.
REQ-024 Grant in cycle T SHALL register sram_en=1, sram_addr={addr[31:2],2'b00}, sram_wen, sram_wdata for cycle T+1; no grant -> sram_en=0, sram_wen=0, addr/wdata=0.
REQ-025 Loads and fetches SHALL drive sram_wen=0000.
REQ-026 Byte store: sram_wen=0001<<addr[1:0], sram_wdata={4{wdata[7:0]}}.
REQ-027 Half store: sram_wen=addr[1]?1100:0011, sram_wdata={2{wdata[15:0]}}; word store: 1111, wdata unchanged.
REQ-028 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11 SHALL be acked with data_err=1, issue no SRAM access, and consume the grant slot (no inst grant that cycle).
REQ-029 SHALL track owner of each issued read; in cycle T+2 pulse inst_rvalid or data_rvalid for one cycle with rdata=sram_rdata; stores produce no rvalid.
REQ-030 Back-to-back grants SHALL be supported: sram_en may be high every cycle, up to two reads in flight.
REQ-031 inst_rdata/data_rdata SHALL hold last delivered value when rvalid low.
REQ-032 stallreq SHALL equal (inst_req & ~inst_ack) | (data_req & ~data_ack), combinational.

Reset
REQ-033 On rst: sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0, rvalids=0, rdata=0, starve counter=0, in-flight tracking cleared.
REQ-034 Reads in flight at reset SHALL never produce rvalid; acks are suppressed while rst high.

Verification
REQ-035 Both req high, data load addr 0x104 size 10 -> data_ack T, sram_en/addr 0x104/wen 0000 T+1, data_rvalid with sram_rdata T+2, inst_ack low, stallreq=1 at T.
REQ-036 Byte store addr 0x203, wdata 0x000000AB -> sram_wen=1000, sram_addr=0x200, sram_wdata=0xABABABAB.
REQ-037 Half store addr 0x101 -> data_ack=1, data_err=1, sram_en=0 next cycle, no rvalid.
REQ-038 inst_req held, data_req held 6 cycles, STARVE_MAX=4 -> 4 data grants, inst grant on 5th cycle, data resumes.
REQ-039 Alternating inst/data reads every cycle -> sram_en high continuously, rvalids routed to correct owner in order.
REQ-040 rst asserted one cycle after a load grant -> no data_rvalid, all outputs zero next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store requests onto one registered
// SRAM port, returning read data to whichever requester issued each read.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_ack,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_ack,
   output logic        data_err,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   output logic        stallreq
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

   logic [CW-1:0] starve_reg;
   logic          starve_hit;
   logic          misaligned;
   logic          issue;
   logic          issue_read;
   logic [3:0]    wen_next;
   logic [31:0]   wdata_next;
   logic [31:0]   addr_next;

   // Two-stage owner pipeline: stage 1 matches sram_en, stage 2 matches sram_rdata.
   logic rd1_valid_reg, rd1_inst_reg;
   logic rd2_valid_reg, rd2_inst_reg;
   logic [31:0] inst_hold_reg, data_hold_reg;

   always_comb begin
      starve_hit = inst_req && (starve_reg == STARVE_LIMIT);
      data_ack   = !rst && data_req && !starve_hit;
      inst_ack   = !rst && inst_req && !data_ack;

      unique case (data_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = data_addr[0];
         2'b10:   misaligned = |data_addr[1:0];
         default: misaligned = 1'b1;
      endcase

      data_err = data_ack && misaligned;
      stallreq = (inst_req && !inst_ack) || (data_req && !data_ack);

      wen_next   = 4'b0000;
      wdata_next = 32'd0;
      if (data_we) begin
         unique case (data_size)
            2'b00: begin
               wen_next   = 4'b0001 << data_addr[1:0];
               wdata_next = {4{data_wdata[7:0]}};
            end
            2'b01: begin
               wen_next   = data_addr[1] ? 4'b1100 : 4'b0011;
               wdata_next = {2{data_wdata[15:0]}};
            end
            default: begin
               wen_next   = 4'b1111;
               wdata_next = data_wdata;
            end
         endcase
      end

      // Erroneous data requests still win the slot but never touch the SRAM.
      issue      = inst_ack || (data_ack && !misaligned);
      issue_read = inst_ack || (data_ack && !misaligned && !data_we);
      addr_next  = inst_ack ? inst_addr : data_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_reg    <= '0;
         sram_en       <= 1'b0;
         sram_wen      <= 4'b0000;
         sram_addr     <= 32'd0;
         sram_wdata    <= 32'd0;
         rd1_valid_reg <= 1'b0;
         rd1_inst_reg  <= 1'b0;
         rd2_valid_reg <= 1'b0;
         rd2_inst_reg  <= 1'b0;
         inst_hold_reg <= 32'd0;
         data_hold_reg <= 32'd0;
      end else begin
         if (inst_ack || !inst_req)
            starve_reg <= '0;
         else if (data_ack && starve_reg != STARVE_LIMIT)
            starve_reg <= starve_reg + 1'b1;

         if (issue) begin
            sram_en    <= 1'b1;
            sram_addr  <= {addr_next[31:2], 2'b00};
            sram_wen   <= inst_ack ? 4'b0000 : wen_next;
            sram_wdata <= inst_ack ? 32'd0 : wdata_next;
         end else begin
            sram_en    <= 1'b0;
            sram_addr  <= 32'd0;
            sram_wen   <= 4'b0000;
            sram_wdata <= 32'd0;
         end

         rd1_valid_reg <= issue_read;
         rd1_inst_reg  <= inst_ack;
         rd2_valid_reg <= rd1_valid_reg;
         rd2_inst_reg  <= rd1_inst_reg;

         if (inst_rvalid) inst_hold_reg <= sram_rdata;
         if (data_rvalid) data_hold_reg <= sram_rdata;
      end
   end

   always_comb begin
      inst_rvalid = !rst && rd2_valid_reg && rd2_inst_reg;
      data_rvalid = !rst && rd2_valid_reg && !rd2_inst_reg;
      inst_rdata  = inst_rvalid ? sram_rdata : inst_hold_reg;
      data_rdata  = data_rvalid ? sram_rdata : data_hold_reg;
   end

endmodule
